// File: rtl/ld_seq_pkg.sv
// Shared definitions for the accumulator-A memory transfer sequencer: states, mode
// encodings, datapath bit positions and the state-to-control decode.
package ld_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IMM_LO_A = 3'd1,
    ST_IMM_LO_D = 3'd2,
    ST_IMM_HI_A = 3'd3,
    ST_IMM_HI_D = 3'd4,
    ST_MEM_A    = 3'd5,
    ST_MEM_D    = 3'd6,
    ST_FETCH    = 3'd7
  } state_t;

  localparam logic [1:0] MODE_A16 = 2'b00;
  localparam logic [1:0] MODE_A8  = 2'b01;
  localparam logic [1:0] MODE_C   = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  // Bit positions inside the datapath control bundle common to all sequencers.
  localparam int W8_Z       = 1;
  localparam int W8_W       = 0;
  localparam int R16_PC     = 5;
  localparam int R16_WZ     = 0;
  localparam int W16_PC     = 5;
  localparam int INC16_ADDR = 0;
  localparam int ALU8_A     = 0;

  typedef struct packed {
    logic       ir_fetch;
    logic [7:0] write8;
    logic [5:0] read16;
    logic [5:0] write16;
    logic [1:0] read_alu8;
    logic [1:0] write_alu8;
    logic       move_reg;
    logic       bus_in;
    logic       bus_out;
    logic       address_out;
    logic [1:0] increment16;
    logic       high_page;
    logic       low_src_c;
  } ctrl_t;

  function automatic state_t first_state(input logic [1:0] mode);
    return (mode == MODE_C) ? ST_MEM_A : ST_IMM_LO_A;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t st, input logic [1:0] mode, input logic dir);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IMM_LO_A, ST_IMM_HI_A: begin
        c.address_out             = 1'b1;
        c.read16[R16_PC]          = 1'b1;
        c.write16[W16_PC]         = 1'b1;
        c.increment16[INC16_ADDR] = 1'b1;
      end
      ST_IMM_LO_D: begin
        c.bus_in       = 1'b1;
        c.write8[W8_Z] = 1'b1;
      end
      ST_IMM_HI_D: begin
        c.bus_in       = 1'b1;
        c.write8[W8_W] = 1'b1;
      end
      ST_MEM_A: begin
        c.address_out    = 1'b1;
        c.read16[R16_WZ] = 1'b1;
        c.high_page      = (mode != MODE_A16);
        c.low_src_c      = (mode == MODE_C);
      end
      ST_MEM_D: begin
        if (dir) begin
          c.bus_in             = 1'b1;
          c.write_alu8[ALU8_A] = 1'b1;
        end else begin
          c.bus_out           = 1'b1;
          c.read_alu8[ALU8_A] = 1'b1;
          c.move_reg          = 1'b1;
        end
      end
      ST_FETCH: c.ir_fetch = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ld_seq_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; holds at zero rather than wrapping.
module ld_seq_wait_counter (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Load,
  input  logic [3:0] i_Load_Val,
  input  logic       i_Dec,
  output logic       o_Zero
);

  logic [3:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (i_Load) begin
      count_d = i_Load_Val;
    end else if (i_Dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Zero = (count_q == 4'd0);

endmodule

// File: rtl/ld_mem_a_sequencer.sv
// Microcode sequencer for LD/LDH transfers of A to/from a direct, high-page or (C) address.
// Valid/ready: i_Start is accepted only in IDLE or on the FETCH exit tick; o_Busy marks non-IDLE.
module ld_mem_a_sequencer
  import ld_seq_pkg::*;
#(
  parameter int SUPPORT_HIGH_PAGE = 1,
  parameter int WAIT_STATES       = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Tick,
  input  logic       i_Start,
  input  logic [1:0] i_Mode,
  input  logic       i_Dir,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Illegal,
  output logic       o_IR_Fetch,
  output logic [7:0] o_Write8,
  output logic [5:0] o_Read16,
  output logic [5:0] o_Write16,
  output logic [1:0] o_ReadALU8,
  output logic [1:0] o_WriteALU8,
  output logic       o_Move_Reg,
  output logic       o_Bus_In,
  output logic       o_Bus_Out,
  output logic       o_Address_Out,
  output logic [1:0] o_Increment16,
  output logic       o_High_Page,
  output logic       o_Low_Src_C,
  output logic [2:0] o_Dbg_State
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t     state_d, state_q;
  logic [1:0] mode_d, mode_q;
  logic       dir_d, dir_q;
  logic       done_d, done_q;
  logic       illegal_d, illegal_q;
  ctrl_t      ctrl_d, ctrl_q;
  logic       take_start, start_legal;
  logic       wait_load, wait_dec, wait_zero;

  ld_seq_wait_counter u_wait (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Load     (wait_load),
    .i_Load_Val (WAIT_INIT),
    .i_Dec      (wait_dec),
    .o_Zero     (wait_zero)
  );

  assign wait_dec    = (state_q == ST_MEM_D) && i_Tick;
  assign start_legal = (i_Mode == MODE_A16) ||
                       (((i_Mode == MODE_A8) || (i_Mode == MODE_C)) && (SUPPORT_HIGH_PAGE != 0));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    wait_load  = 1'b0;
    take_start = 1'b0;
    case (state_q)
      ST_IDLE:     take_start = i_Start;
      ST_IMM_LO_A: if (i_Tick) state_d = ST_IMM_LO_D;
      ST_IMM_LO_D: if (i_Tick) state_d = (mode_q == MODE_A8) ? ST_MEM_A : ST_IMM_HI_A;
      ST_IMM_HI_A: if (i_Tick) state_d = ST_IMM_HI_D;
      ST_IMM_HI_D: if (i_Tick) state_d = ST_MEM_A;
      ST_MEM_A: begin
        if (i_Tick) begin
          state_d   = ST_MEM_D;
          wait_load = 1'b1;
        end
      end
      ST_MEM_D:    if (i_Tick && wait_zero) state_d = ST_FETCH;
      ST_FETCH: begin
        if (i_Tick) begin
          done_d     = 1'b1;
          state_d    = ST_IDLE;
          take_start = i_Start;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
    // A start overrides the default next state, including the back-to-back FETCH exit.
    if (take_start) begin
      if (start_legal) begin
        state_d = first_state(i_Mode);
        mode_d  = i_Mode;
        dir_d   = i_Dir;
      end else begin
        illegal_d = 1'b1;
      end
    end
    ctrl_d = decode_ctrl(state_d, mode_d, dir_d);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_A16;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign o_Busy        = (state_q != ST_IDLE);
  assign o_Done        = done_q;
  assign o_Illegal     = illegal_q;
  assign o_IR_Fetch    = ctrl_q.ir_fetch;
  assign o_Write8      = ctrl_q.write8;
  assign o_Read16      = ctrl_q.read16;
  assign o_Write16     = ctrl_q.write16;
  assign o_ReadALU8    = ctrl_q.read_alu8;
  assign o_WriteALU8   = ctrl_q.write_alu8;
  assign o_Move_Reg    = ctrl_q.move_reg;
  assign o_Bus_In      = ctrl_q.bus_in;
  assign o_Bus_Out     = ctrl_q.bus_out;
  assign o_Address_Out = ctrl_q.address_out;
  assign o_Increment16 = ctrl_q.increment16;
  assign o_High_Page   = ctrl_q.high_page;
  assign o_Low_Src_C   = ctrl_q.low_src_c;
  assign o_Dbg_State   = state_q;

endmodule

// File: tb/tb_ld_mem_a_sequencer.sv
// Bench for ld_mem_a_sequencer: three configurations (default, WAIT_STATES=3, no high page)
// driven from a vector table plus back-to-back and mid-transfer reset sequences.
module tb_ld_mem_a_sequencer;
  import ld_seq_pkg::*;

  localparam int OW = 39;
  localparam logic [OW-1:0] HOLD_MASK = ~(39'h3 << 33);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tick  = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic       dir   = 1'b0;
  logic [1:0] sel   = 2'd0;

  logic [OW-1:0] obs_w [3];
  logic [OW-1:0] obs_sel;
  assign obs_sel = obs_w[sel];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       busy, done, ill, irf, mv, bi, bo, ao, hp, lsc;
    logic [7:0] w8;
    logic [5:0] r16, w16;
    logic [1:0] ra, wa, inc;
    logic [2:0] st;
    ld_mem_a_sequencer #(
      .SUPPORT_HIGH_PAGE ((g == 2) ? 0 : 1),
      .WAIT_STATES       ((g == 1) ? 3 : 0)
    ) u_dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Tick        (tick),
      .i_Start       (start && (sel == g)),
      .i_Mode        (mode),
      .i_Dir         (dir),
      .o_Busy        (busy),
      .o_Done        (done),
      .o_Illegal     (ill),
      .o_IR_Fetch    (irf),
      .o_Write8      (w8),
      .o_Read16      (r16),
      .o_Write16     (w16),
      .o_ReadALU8    (ra),
      .o_WriteALU8   (wa),
      .o_Move_Reg    (mv),
      .o_Bus_In      (bi),
      .o_Bus_Out     (bo),
      .o_Address_Out (ao),
      .o_Increment16 (inc),
      .o_High_Page   (hp),
      .o_Low_Src_C   (lsc),
      .o_Dbg_State   (st)
    );
    assign obs_w[g] = {st, busy, done, ill, irf, w8, r16, w16, ra, wa, mv, bi, bo, ao, inc, hp, lsc};
  end

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference control values written out literally from the datapath bit map.
  function automatic logic [OW-1:0] mk_obs(input logic [2:0] st, input logic [1:0] m, input logic d,
                                           input logic dn, input logic il);
    logic       busy, irf, mv, bi, bo, ao, hp, lsc;
    logic [7:0] w8;
    logic [5:0] r16, w16;
    logic [1:0] ra, wa, inc;
    busy = (st != ST_IDLE);
    {irf, mv, bi, bo, ao, hp, lsc} = '0;
    w8 = 8'h00; r16 = 6'h00; w16 = 6'h00; ra = 2'b00; wa = 2'b00; inc = 2'b00;
    case (st)
      ST_IMM_LO_A, ST_IMM_HI_A: begin ao = 1'b1; r16 = 6'h20; w16 = 6'h20; inc = 2'b01; end
      ST_IMM_LO_D: begin bi = 1'b1; w8 = 8'h02; end
      ST_IMM_HI_D: begin bi = 1'b1; w8 = 8'h01; end
      ST_MEM_A:    begin ao = 1'b1; r16 = 6'h01; hp = (m == 2'b01) || (m == 2'b10); lsc = (m == 2'b10); end
      ST_MEM_D: begin
        if (d) begin bi = 1'b1; wa = 2'b01; end
        else begin bo = 1'b1; ra = 2'b01; mv = 1'b1; end
      end
      ST_FETCH:    irf = 1'b1;
      default: ;
    endcase
    return {st, busy, dn, il, irf, w8, r16, w16, ra, wa, mv, bi, bo, ao, inc, hp, lsc};
  endfunction

  task automatic push_path(input logic [1:0] m, input logic d, input int w, input bit first_done);
    logic [2:0] seq[$];
    seq = {};
    if (m != 2'b10) begin
      seq.push_back(ST_IMM_LO_A);
      seq.push_back(ST_IMM_LO_D);
      if (m == 2'b00) begin
        seq.push_back(ST_IMM_HI_A);
        seq.push_back(ST_IMM_HI_D);
      end
    end
    seq.push_back(ST_MEM_A);
    for (int i = 0; i <= w; i++) seq.push_back(ST_MEM_D);
    seq.push_back(ST_FETCH);
    foreach (seq[i]) exp_q.push_back(mk_obs(seq[i], m, d, (i == 0) && first_done, 1'b0));
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic [1:0] s, input logic [1:0] m1, input logic d1, input bit legal1,
                         input bit b2b, input logic [1:0] m2, input logic d2, input bit gap,
                         output int first_done, output int done_cnt);
    int            w, n_samp;
    logic [OW-1:0] cur, e, last;
    bit            ticked, b2b_used, tk;
    w = (s == 2'd1) ? 3 : 0;
    exp_q.delete();
    if (legal1) begin
      push_path(m1, d1, w, 1'b0);
      if (b2b) push_path(m2, d2, w, 1'b1);
      exp_q.push_back(mk_obs(ST_IDLE, 2'b00, 1'b0, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(mk_obs(ST_IDLE, 2'b00, 1'b0, 1'b0, 1'b1));
    end
    first_done = 0; done_cnt = 0; n_samp = 0; b2b_used = 1'b0; last = '0;
    @(negedge clk);
    sel = s; start = 1'b1; mode = m1; dir = d1;
    tick = gap ? 1'($urandom_range(0, 1)) : 1'b1;
    ticked = 1'b1;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      @(negedge clk);
      cur = obs_sel;
      if (ticked) begin
        n_samp++;
        e = exp_q.pop_front();
        check("seq", cur, e);
        last = e;
        if (cur[34] && first_done == 0) first_done = n_samp;
      end else begin
        check("hold", cur & HOLD_MASK, last & HOLD_MASK);
      end
      if (cur[34]) done_cnt++;
      tk = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      tick = tk;
      start = 1'b0;
      mode = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      if (b2b && !b2b_used && tk && cur[38:36] == ST_FETCH) begin
        start = 1'b1; mode = m2; dir = d2; b2b_used = 1'b1;
      end else if (gap && cur[38:36] != ST_FETCH && cur[38:36] != ST_IDLE && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
      end
      ticked = tk;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: %0d expected samples left", exp_q.size());
    end
    start = 1'b0; tick = 1'b1;
    @(negedge clk);
    check("post_idle", obs_sel, mk_obs(ST_IDLE, 2'b00, 1'b0, 1'b0, 1'b0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] sel;
    logic [1:0] mode;
    logic       dir;
    bit         legal;
    bit         gap;
    int         exp_lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int fd, dc;
    tbl[0]  = '{2'd0, 2'b00, 1'b0, 1'b1, 1'b0, 8};
    tbl[1]  = '{2'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8};
    tbl[2]  = '{2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 6};
    tbl[3]  = '{2'd0, 2'b01, 1'b0, 1'b1, 1'b0, 6};
    tbl[4]  = '{2'd0, 2'b10, 1'b0, 1'b1, 1'b0, 4};
    tbl[5]  = '{2'd0, 2'b11, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{2'd1, 2'b10, 1'b1, 1'b1, 1'b0, 7};
    tbl[7]  = '{2'd1, 2'b00, 1'b0, 1'b1, 1'b1, 11};
    tbl[8]  = '{2'd1, 2'b01, 1'b1, 1'b1, 1'b1, 9};
    tbl[9]  = '{2'd2, 2'b01, 1'b1, 1'b0, 1'b0, 0};
    tbl[10] = '{2'd2, 2'b10, 1'b0, 1'b0, 1'b0, 0};
    tbl[11] = '{2'd2, 2'b00, 1'b1, 1'b1, 1'b0, 8};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1 check("reset_state", obs_sel, '0);
    end
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].sel, tbl[i].mode, tbl[i].dir, tbl[i].legal, 1'b0, 2'b00, 1'b0, tbl[i].gap, fd, dc);
      check_int($sformatf("latency_v%0d", i), fd, tbl[i].exp_lat);
      check_int($sformatf("done_cnt_v%0d", i), dc, tbl[i].legal ? 1 : 0);
    end

    // back-to-back: a16 store then a8 load started on the FETCH exit tick
    run_txn(2'd0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, fd, dc);
    check_int("b2b_first_done", fd, 8);
    check_int("b2b_done_cnt", dc, 2);

    // reset during MEM_D of a store
    @(negedge clk);
    sel = 2'd0; start = 1'b1; mode = 2'b00; dir = 1'b0; tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20 && obs_sel[38:36] != ST_MEM_D; n++) @(negedge clk);
    check_int("reach_mem_d", int'(obs_sel[38:36]), int'(ST_MEM_D));
    #2 rst = 1'b1;
    #1 check("rst_async", obs_sel, '0);
    @(negedge clk);
    check("rst_hold", obs_sel, '0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_after", obs_sel, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
